// File: rtl/cemdu_pkg.sv
// Shared symbols for the CE0 multiply/divide unit: op encodings, FSM states and iteration count.
package cemdu_pkg;

  localparam logic [2:0] CE_OP_NONE  = 3'b000;
  localparam logic [2:0] CE_OP_MULT  = 3'b001;
  localparam logic [2:0] CE_OP_MULTU = 3'b010;
  localparam logic [2:0] CE_OP_DIV   = 3'b011;
  localparam logic [2:0] CE_OP_DIVU  = 3'b100;
  localparam logic [2:0] CE_OP_MFHI  = 3'b101;
  localparam logic [2:0] CE_OP_MFLO  = 3'b110;
  localparam logic [2:0] CE_OP_RSVD  = 3'b111;

  localparam int unsigned CE_ITER      = 32;
  localparam logic [4:0]  CE_LAST_ITER = 5'(CE_ITER - 1);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StFix  = 2'b10
  } ce_state_e;

  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == CE_OP_MULT) || (op == CE_OP_MULTU) || (op == CE_OP_DIV) || (op == CE_OP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == CE_OP_DIV) || (op == CE_OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == CE_OP_MULT) || (op == CE_OP_DIV);
  endfunction

endpackage

// File: rtl/cemdu_step.sv
// One iteration of the shared 33-bit adder: shift-add multiply or restoring divide step.
module cemdu_step (
  input  logic        i_is_div,
  input  logic [63:0] i_acc,
  input  logic [31:0] i_opnd,
  output logic [63:0] o_acc
);

  logic [32:0] w_a;
  logic [32:0] w_b;
  logic        w_cin;
  logic [33:0] w_sum;

  // Divide subtracts the divisor from {rem, next dividend bit}; multiply adds to the high half.
  always_comb begin
    if (i_is_div) begin
      w_a   = i_acc[63:31];
      w_b   = ~{1'b0, i_opnd};
      w_cin = 1'b1;
    end else begin
      w_a   = {1'b0, i_acc[63:32]};
      w_b   = {1'b0, i_opnd};
      w_cin = 1'b0;
    end
  end

  assign w_sum = {1'b0, w_a} + {1'b0, w_b} + {33'b0, w_cin};

  // w_sum[33] is the no-borrow flag of the subtract.
  always_comb begin
    if (i_is_div) begin
      if (w_sum[33]) begin
        o_acc = {w_sum[31:0], i_acc[30:0], 1'b1};
      end else begin
        o_acc = {i_acc[62:0], 1'b0};
      end
    end else if (i_acc[0]) begin
      o_acc = {w_sum[32:0], i_acc[31:1]};
    end else begin
      o_acc = {1'b0, i_acc[63:1]};
    end
  end

endmodule

// File: rtl/cemdu.sv
// CE0 iterative multiply/divide unit: 32-step engine with HI/LO result registers and MFHI/MFLO read.
module cemdu
  import cemdu_pkg::*;
(
  input  logic        SYSCLK,
  input  logic        RESET_D1_R,
  input  logic        CLMI_RHOLD,
  input  logic [2:0]  CEOP_E_P,
  input  logic [31:0] REGA_E_R,
  input  logic [31:0] REGBI_E_R,
  output logic [31:0] CE0_RES_E,
  output logic        CE0_SEL_E_R,
  output logic        CE0_STALL_E,
  output logic        CE0_BUSY
);

  ce_state_e   r_state;
  logic [4:0]  r_cnt;
  logic [2:0]  r_ceop;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [63:0] r_acc;
  logic [31:0] r_opnd;
  logic        r_is_div;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_dz;

  logic        w_start;
  logic        w_sgn;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [63:0] w_step;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  assign w_start = !CLMI_RHOLD && is_muldiv(r_ceop);
  assign w_sgn   = is_signed_op(r_ceop);
  assign w_abs_a = (w_sgn && REGA_E_R[31]) ? -REGA_E_R : REGA_E_R;
  assign w_abs_b = (w_sgn && REGBI_E_R[31]) ? -REGBI_E_R : REGBI_E_R;

  cemdu_step u_step (
    .i_is_div (r_is_div),
    .i_acc    (r_acc),
    .i_opnd   (r_opnd),
    .o_acc    (w_step)
  );

  // Divide by zero bypasses quotient sign correction so LO is always all ones.
  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_dz ? 32'hFFFF_FFFF : (r_neg_q ? -r_acc[31:0] : r_acc[31:0]);
  assign w_rem  = r_neg_r ? -r_acc[63:32] : r_acc[63:32];

  always_ff @(posedge SYSCLK or posedge RESET_D1_R) begin
    if (RESET_D1_R) begin
      r_ceop <= CE_OP_NONE;
    end else if (!CLMI_RHOLD) begin
      r_ceop <= CEOP_E_P;
    end
  end

  // A new MULT/DIV restarts the engine from any state, discarding the op in flight.
  always_ff @(posedge SYSCLK or posedge RESET_D1_R) begin
    if (RESET_D1_R) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
    end else if (w_start) begin
      r_state  <= StRun;
      r_cnt    <= '0;
      r_is_div <= is_div_op(r_ceop);
      r_dz     <= is_div_op(r_ceop) && (REGBI_E_R == 32'd0);
      r_neg_q  <= w_sgn && (REGA_E_R[31] ^ REGBI_E_R[31]);
      r_neg_r  <= w_sgn && REGA_E_R[31];
      if (is_div_op(r_ceop)) begin
        r_acc  <= {32'd0, w_abs_a};
        r_opnd <= w_abs_b;
      end else begin
        r_acc  <= {32'd0, w_abs_b};
        r_opnd <= w_abs_a;
      end
    end else begin
      unique case (r_state)
        StRun: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == CE_LAST_ITER) begin
            r_state <= StFix;
          end
        end
        StFix: begin
          r_state <= StIdle;
          if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign CE0_SEL_E_R = (r_ceop == CE_OP_MFHI) || (r_ceop == CE_OP_MFLO);
  assign CE0_BUSY    = (r_state != StIdle);
  assign CE0_STALL_E = CE0_SEL_E_R & CE0_BUSY;

  always_comb begin
    case (r_ceop)
      CE_OP_MFHI: CE0_RES_E = r_hi;
      CE_OP_MFLO: CE0_RES_E = r_lo;
      default:    CE0_RES_E = '0;
    endcase
  end

endmodule

// File: tb/tb_cemdu.sv
// Self-checking bench for cemdu: directed corner cases plus random ops against an arithmetic model.
module tb_cemdu;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MFHI  = 3'b101;
  localparam logic [2:0] OP_MFLO  = 3'b110;
  localparam logic [2:0] OP_RSVD  = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold_drv;
  logic        hold_follow;
  logic        w_hold;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] res;
  logic        sel;
  logic        stall;
  logic        busy;

  int checks = 0;
  int errors = 0;

  assign w_hold = hold_follow ? stall : hold_drv;

  cemdu dut (
    .SYSCLK      (clk),
    .RESET_D1_R  (rst),
    .CLMI_RHOLD  (w_hold),
    .CEOP_E_P    (op),
    .REGA_E_R    (a),
    .REGBI_E_R   (b),
    .CE0_RES_E   (res),
    .CE0_SEL_E_R (sel),
    .CE0_STALL_E (stall),
    .CE0_BUSY    (busy)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit integer arithmetic, truncating division.
  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint      sx;
    longint      sy;
    longint      q;
    longint      r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = '0;
    case (o)
      OP_MULT:  p = sx * sy;
      OP_MULTU: p = {32'd0, x} * {32'd0, y};
      OP_DIV: begin
        if (y == 32'd0) begin
          p = {x, 32'hFFFF_FFFF};
        end else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
      OP_DIVU: begin
        if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
        else            p = {x % y, x / y};
      end
      default: p = '0;
    endcase
    hi = p[63:32];
    lo = p[31:0];
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o;
    a  = x;
    b  = y;
    @(posedge clk); @(negedge clk);
    op = OP_NONE;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    op = OP_MFHI;
    @(posedge clk); @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL read_stall: stall=%0b required 0", stall);
    end
    hi = res;
    op = OP_MFLO;
    @(posedge clk); @(negedge clk);
    lo = res;
    op = OP_NONE;
  endtask

  task automatic run_check(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                           input string tag, input bit check_lat);
    int          n;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] ehi;
    logic [31:0] elo;
    issue(o, x, y);
    wait_idle(n);
    if (check_lat) begin
      checks++;
      if (n != 33) begin
        errors++;
        $display("FAIL %s busy_cycles: got %0d required 33", tag, n);
      end
    end
    read_hilo(hi, lo);
    model(o, x, y, ehi, elo);
    checks++;
    if (hi !== ehi) begin
      errors++;
      $display("FAIL %s hi: op=%0d a=%h b=%h got %h required %h", tag, o, x, y, hi, ehi);
    end
    checks++;
    if (lo !== elo) begin
      errors++;
      $display("FAIL %s lo: op=%0d a=%h b=%h got %h required %h", tag, o, x, y, lo, elo);
    end
  endtask

  task automatic test_reset();
    logic [31:0] hi;
    logic [31:0] lo;
    rst = 1'b1;
    hold_drv = 1'b0;
    hold_follow = 1'b0;
    op = OP_MFHI;
    a = 32'h1234_5678;
    b = 32'h9ABC_DEF0;
    repeat (3) @(negedge clk);
    checks++;
    if (res !== 32'd0)  begin errors++; $display("FAIL reset_res: got %h required 0", res); end
    checks++;
    if (sel !== 1'b0)   begin errors++; $display("FAIL reset_sel: got %b required 0", sel); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b required 0", stall); end
    checks++;
    if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    op  = OP_NONE;
    rst = 1'b0;
    @(negedge clk);
    read_hilo(hi, lo);
    checks++;
    if ({hi, lo} !== 64'd0) begin
      errors++;
      $display("FAIL reset_hilo: got %h_%h required 0_0", hi, lo);
    end
  endtask

  task automatic test_directed();
    run_check(OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002, "mult_neg1x2", 1'b1);
    run_check(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, "multu_ffx2", 1'b1);
    run_check(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, "div_m7by2", 1'b1);
    run_check(OP_DIVU,  32'h0000_0007, 32'h0000_0000, "divu_by0", 1'b1);
    run_check(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b1);
    run_check(OP_DIV,   32'h8000_0005, 32'h0000_0000, "div_neg_by0", 1'b0);
    run_check(OP_MULT,  32'h8000_0000, 32'h8000_0000, "mult_minmin", 1'b0);
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom_range(1, 4));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = y >> $urandom_range(16, 31);
        default: ;
      endcase
      run_check(o, x, y, "random", 1'b0);
    end
  endtask

  task automatic test_stall_latency();
    int          n;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] ehi;
    logic [31:0] elo;
    x = $urandom;
    y = $urandom;
    model(OP_MULT, x, y, ehi, elo);
    hold_follow = 1'b1;
    op = OP_MULT;
    a  = x;
    b  = y;
    @(posedge clk); @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL stall_cycleN: got %b required 0", stall); end
    op = OP_MFLO;
    @(posedge clk); @(negedge clk);
    n = 0;
    while (stall === 1'b1 && n < 100) begin
      n++;
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if (n != 33) begin errors++; $display("FAIL stall_cycles: got %0d required 33", n); end
    checks++;
    if (res !== elo) begin errors++; $display("FAIL stall_mflo: got %h required %h", res, elo); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL stall_busy: got %b required 0", busy); end
    op = OP_NONE;
    @(posedge clk); @(negedge clk);
    hold_follow = 1'b0;
  endtask

  task automatic test_abort();
    int          n;
    logic [31:0] hi;
    logic [31:0] lo;
    issue(OP_DIV, $urandom, 32'h0000_1235);
    repeat (9) begin @(posedge clk); @(negedge clk); end
    issue(OP_MULTU, 32'd3, 32'd5);
    wait_idle(n);
    checks++;
    if (n != 33) begin errors++; $display("FAIL abort_busy_cycles: got %0d required 33", n); end
    read_hilo(hi, lo);
    checks++;
    if (hi !== 32'd0) begin errors++; $display("FAIL abort_hi: got %h required 0", hi); end
    checks++;
    if (lo !== 32'h0000_000F) begin errors++; $display("FAIL abort_lo: got %h required f", lo); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] hi;
    logic [31:0] lo;
    run_check(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "pre_reset", 1'b0);
    issue(OP_MULT, 32'h7654_3210, 32'h0FED_CBA9);
    repeat (20) begin @(posedge clk); @(negedge clk); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midreset_pre_busy: got %b required 1", busy); end
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b required 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    read_hilo(hi, lo);
    checks++;
    if (hi !== 32'd0) begin errors++; $display("FAIL midreset_mfhi: got %h required 0", hi); end
    checks++;
    if (lo !== 32'd0) begin errors++; $display("FAIL midreset_mflo: got %h required 0", lo); end
  endtask

  task automatic test_hold_nostart();
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] ehi;
    logic [31:0] elo;
    run_check(OP_MULTU, 32'h0001_2345, 32'h0010_0000, "pre_hold", 1'b0);
    model(OP_MULTU, 32'h0001_2345, 32'h0010_0000, ehi, elo);
    hold_drv = 1'b1;
    op = OP_MULT;
    a  = $urandom;
    b  = $urandom;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL hold_busy[%0d]: got %b required 0", i, busy); end
    end
    op = OP_RSVD;
    hold_drv = 1'b0;
    @(posedge clk); @(negedge clk);
    op = OP_NONE;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL rsvd_busy[%0d]: got %b required 0", i, busy); end
    end
    read_hilo(hi, lo);
    checks++;
    if (hi !== ehi) begin errors++; $display("FAIL hold_hi: got %h required %h", hi, ehi); end
    checks++;
    if (lo !== elo) begin errors++; $display("FAIL hold_lo: got %h required %h", lo, elo); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_stall_latency();
    test_abort();
    test_reset_mid();
    test_hold_nostart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
